// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with a double-buffered frame,
// per-digit blanking/blink and decimal points. All outputs are registered.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic [NUM_DIGITS-1:0]     blink_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic                      pending,
  output logic                      frame_start,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic [6:0]                seg_n,
  output logic                      dp_n
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DIG_W   = 4 * NUM_DIGITS;

  typedef struct packed {
    logic [DIG_W-1:0]      digits;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] blink;
    logic [NUM_DIGITS-1:0] dp;
  } frame_t;

  localparam frame_t FRAME_RST = '{digits: '1, blank: '0, blink: '0, dp: '0};

  // Active-low segment pattern (GFEDCBA) for each glyph code; F is blank.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h07;
      4'hB: s = 7'h2F;
      4'hC: s = 7'h11;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic               blink_off, blink_off_nxt;
  frame_t             active, active_nxt;
  frame_t             shadow, shadow_nxt;
  logic               pending_nxt;
  logic               tick, boundary;
  logic [3:0]         cur_code;
  logic               dark;
  logic [NUM_DIGITS-1:0] an_n_nxt;
  logic [6:0]         seg_n_nxt;
  logic               dp_n_nxt;

  // Scan timing, frame commit and blink phase.
  always_comb begin
    tick          = (presc == PRESC_W'(SCAN_DIV - 1));
    boundary      = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    presc_nxt     = tick ? '0 : presc + PRESC_W'(1);
    idx_nxt       = idx;
    blink_cnt_nxt = blink_cnt;
    blink_off_nxt = blink_off;
    active_nxt    = active;
    shadow_nxt    = shadow;
    pending_nxt   = pending;

    if (tick) idx_nxt = boundary ? '0 : idx + IDX_W'(1);

    if (boundary) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_nxt = '0;
        blink_off_nxt = ~blink_off;
      end else begin
        blink_cnt_nxt = blink_cnt + BLINK_W'(1);
      end
      // Commit sees the shadow as it was before any load on this same cycle.
      if (pending) begin
        active_nxt  = shadow;
        pending_nxt = 1'b0;
      end
    end

    if (load) begin
      shadow_nxt  = '{digits: digits_in, blank: blank_in, blink: blink_in, dp: dp_in};
      pending_nxt = 1'b1;
    end
  end

  // Output pattern for the digit currently selected by idx.
  always_comb begin
    cur_code  = active.digits[{idx, 2'b00} +: 4];
    dark      = active.blank[idx] | (active.blink[idx] & blink_off);
    an_n_nxt  = ~(NUM_DIGITS'(1) << idx);
    seg_n_nxt = dark ? 7'h7F : glyph(cur_code);
    dp_n_nxt  = dark ? 1'b1 : ~active.dp[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      active      <= FRAME_RST;
      shadow      <= FRAME_RST;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      an_n        <= '1;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
    end else begin
      presc       <= presc_nxt;
      idx         <= idx_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_off   <= blink_off_nxt;
      active      <= active_nxt;
      shadow      <= shadow_nxt;
      pending     <= pending_nxt;
      frame_start <= boundary;
      an_n        <= an_n_nxt;
      seg_n       <= seg_n_nxt;
      dp_n        <= dp_n_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: cycle-count based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_seven_seg_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned BF = 2;
  localparam int unsigned FL = N * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'hFFFF;
  logic [3:0]  blank_in = '0, blink_in = '0, dp_in = '0;
  logic        pending, frame_start, dp_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blank_in(blank_in),
    .blink_in(blink_in), .dp_in(dp_in), .pending(pending), .frame_start(frame_start),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] glyph [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h07, 7'h2F, 7'h11, 7'h21, 7'h06, 7'h7F};

  // Model: position in the scan follows purely from edges counted since reset.
  int          k = 0;
  int          mi, mf;
  bit          moff, mdark;
  bit          m_valid = 0;
  logic [15:0] m_dig = 16'hFFFF, s_dig = 16'hFFFF;
  logic [3:0]  m_blank = '0, m_blink = '0, m_dp = '0;
  logic [3:0]  s_blank = '0, s_blink = '0, s_dp = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs, e_pend;

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_pend = 1'b0;
      m_dig = 16'hFFFF; m_blank = '0; m_blink = '0; m_dp = '0;
      s_dig = 16'hFFFF; s_blank = '0; s_blink = '0; s_dp = '0;
    end else begin
      mi    = (k / S) % N;
      mf    = k / FL;
      moff  = ((mf / BF) % 2) == 1;
      mdark = m_blank[mi] | (m_blink[mi] & moff);
      e_an  = ~(4'(1) << mi);
      e_seg = mdark ? 7'h7F : glyph[m_dig[4*mi +: 4]];
      e_dp  = mdark ? 1'b1 : ~m_dp[mi];
      k++;
      e_fs  = (k % FL) == 0;
      if (e_fs && e_pend) begin
        m_dig = s_dig; m_blank = s_blank; m_blink = s_blink; m_dp = s_dp;
        e_pend = 1'b0;
      end
      if (load) begin
        s_dig = digits_in; s_blank = blank_in; s_blink = blink_in; s_dp = dp_in;
        e_pend = 1'b1;
      end
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model an_n", 32'(an_n), 32'(e_an));
      chk("model seg_n", 32'(seg_n), 32'(e_seg));
      chk("model dp_n", 32'(dp_n), 32'(e_dp));
      chk("model frame_start", 32'(frame_start), 32'(e_fs));
      chk("model pending", 32'(pending), 32'(e_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_frame(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                            input logic [3:0] dp);
    digits_in = d; blank_in = bl; blink_in = bk; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk("frame_start timeout", 32'(frame_start), 32'd1);
  endtask

  logic [3:0] an_l  [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_l [0:3] = '{7'h40, 7'h79, 7'h24, 7'h30};
  int on_cnt, off_cnt;

  initial begin
    // Reset held and released
    repeat (3) step();
    chk("reset seg_n", 32'(seg_n), 32'h7F);
    chk("reset an_n", 32'(an_n), 32'hF);
    chk("reset pending", 32'(pending), 32'd0);
    rst = 1'b0;
    step();
    chk("post-reset an_n", 32'(an_n), 32'hE);
    chk("post-reset seg_n", 32'(seg_n), 32'h7F);

    // Mid-frame load, shown from next frame
    repeat (5) step();
    load_frame(16'h3210, 4'h0, 4'h0, 4'h0);
    chk("load pending", 32'(pending), 32'd1);
    chk("unchanged seg_n", 32'(seg_n), 32'h7F);
    wait_fs();
    step();
    for (int d = 0; d < 4; d++) begin
      chk("3210 an_n", 32'(an_n), 32'(an_l[d]));
      chk("3210 seg_n", 32'(seg_n), 32'(seg_l[d]));
      repeat (S) step();
    end

    // Last load wins
    load_frame(16'h1111, 4'h0, 4'h0, 4'h0);
    load_frame(16'h9999, 4'h0, 4'h0, 4'h0);
    wait_fs();
    step();
    for (int d = 0; d < 4; d++) begin
      chk("9999 seg_n", 32'(seg_n), 32'h10);
      repeat (S) step();
    end

    // Load on the boundary cycle
    wait_fs();
    repeat (2) step();
    load_frame(16'h5555, 4'h0, 4'h0, 4'h0);
    repeat (12) step();
    load_frame(16'h7777, 4'h0, 4'h0, 4'h0);
    chk("boundary frame_start", 32'(frame_start), 32'd1);
    chk("boundary pending", 32'(pending), 32'd1);
    step();
    chk("boundary old seg_n", 32'(seg_n), 32'h12);
    wait_fs();
    step();
    chk("boundary new seg_n", 32'(seg_n), 32'h78);
    chk("boundary pending clear", 32'(pending), 32'd0);

    // Blink, blank and decimal point
    load_frame(16'hCBA8, 4'b0100, 4'b0001, 4'b1000);
    wait_fs();
    on_cnt = 0;
    off_cnt = 0;
    for (int fr = 0; fr < 4; fr++) begin
      step();
      if (seg_n == 7'h00) on_cnt++;
      if (seg_n == 7'h7F) off_cnt++;
      chk("d0 dp_n", 32'(dp_n), 32'd1);
      repeat (S) step();
      chk("d1 seg_n", 32'(seg_n), 32'h07);
      repeat (S) step();
      chk("d2 blank seg_n", 32'(seg_n), 32'h7F);
      chk("d2 an_n", 32'(an_n), 32'hB);
      repeat (S) step();
      chk("d3 seg_n", 32'(seg_n), 32'h11);
      chk("d3 dp_n", 32'(dp_n), 32'd0);
      chk("d3 an_n", 32'(an_n), 32'h7);
      repeat (S - 1) step();
    end
    chk("blink on frames", 32'(on_cnt), 32'd2);
    chk("blink off frames", 32'(off_cnt), 32'd2);

    // Reset mid-frame discards pending load
    load_frame(16'h4321, 4'h0, 4'h0, 4'h0);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst pending", 32'(pending), 32'd0);
    chk("rst seg_n", 32'(seg_n), 32'h7F);
    chk("rst an_n", 32'(an_n), 32'hF);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;
    step();
    chk("rst release an_n", 32'(an_n), 32'hE);
    wait_fs();
    step();
    chk("rst shadow discarded seg_n", 32'(seg_n), 32'h7F);
    chk("rst shadow pending", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
